// File: rtl/sha256_compress.sv
// SHA-256 compression stage.
// Takes the 64 schedule words of one block, one word per w_valid/w_ready handshake,
// and runs one round per accepted word. It then adds the chaining value to the
// working variables to produce the 256-bit digest.
module sha256_compress #(
   parameter int ROUNDS = 64,
   parameter int CNT_W  = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         use_iv,
   input  logic [255:0] h_in,
   input  logic         w_valid,
   input  logic [31:0]  w_data,
   output logic         w_ready,
   output logic         busy,
   output logic         digest_valid,
   output logic [255:0] digest
);

   typedef enum logic [1:0] {IDLE, LOAD, ROUND, FINAL} state_t;

   localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS - 1);
   localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   state_t           stateReg, stateNext;
   logic [CNT_W-1:0] roundReg;
   logic [31:0]      chainReg [8];   // lane 0 is H0
   logic [31:0]      varReg [8];     // lane 0 = a ... lane 7 = h
   logic [31:0]      digestReg [8];
   logic             digestValidReg;

   logic [31:0]      chainSel [8];
   logic [31:0]      laneSum [8];
   logic [31:0]      kWord, bigS0, bigS1, chE, majA, t1, t2;
   logic             transfer;

   // Round constants, indexed by the round counter.
   function automatic logic [31:0] kRom(input logic [5:0] t);
      case (t)
         6'd0:  kRom = 32'h428a2f98;  6'd1:  kRom = 32'h71374491;
         6'd2:  kRom = 32'hb5c0fbcf;  6'd3:  kRom = 32'he9b5dba5;
         6'd4:  kRom = 32'h3956c25b;  6'd5:  kRom = 32'h59f111f1;
         6'd6:  kRom = 32'h923f82a4;  6'd7:  kRom = 32'hab1c5ed5;
         6'd8:  kRom = 32'hd807aa98;  6'd9:  kRom = 32'h12835b01;
         6'd10: kRom = 32'h243185be;  6'd11: kRom = 32'h550c7dc3;
         6'd12: kRom = 32'h72be5d74;  6'd13: kRom = 32'h80deb1fe;
         6'd14: kRom = 32'h9bdc06a7;  6'd15: kRom = 32'hc19bf174;
         6'd16: kRom = 32'he49b69c1;  6'd17: kRom = 32'hefbe4786;
         6'd18: kRom = 32'h0fc19dc6;  6'd19: kRom = 32'h240ca1cc;
         6'd20: kRom = 32'h2de92c6f;  6'd21: kRom = 32'h4a7484aa;
         6'd22: kRom = 32'h5cb0a9dc;  6'd23: kRom = 32'h76f988da;
         6'd24: kRom = 32'h983e5152;  6'd25: kRom = 32'ha831c66d;
         6'd26: kRom = 32'hb00327c8;  6'd27: kRom = 32'hbf597fc7;
         6'd28: kRom = 32'hc6e00bf3;  6'd29: kRom = 32'hd5a79147;
         6'd30: kRom = 32'h06ca6351;  6'd31: kRom = 32'h14292967;
         6'd32: kRom = 32'h27b70a85;  6'd33: kRom = 32'h2e1b2138;
         6'd34: kRom = 32'h4d2c6dfc;  6'd35: kRom = 32'h53380d13;
         6'd36: kRom = 32'h650a7354;  6'd37: kRom = 32'h766a0abb;
         6'd38: kRom = 32'h81c2c92e;  6'd39: kRom = 32'h92722c85;
         6'd40: kRom = 32'ha2bfe8a1;  6'd41: kRom = 32'ha81a664b;
         6'd42: kRom = 32'hc24b8b70;  6'd43: kRom = 32'hc76c51a3;
         6'd44: kRom = 32'hd192e819;  6'd45: kRom = 32'hd6990624;
         6'd46: kRom = 32'hf40e3585;  6'd47: kRom = 32'h106aa070;
         6'd48: kRom = 32'h19a4c116;  6'd49: kRom = 32'h1e376c08;
         6'd50: kRom = 32'h2748774c;  6'd51: kRom = 32'h34b0bcb5;
         6'd52: kRom = 32'h391c0cb3;  6'd53: kRom = 32'h4ed8aa4a;
         6'd54: kRom = 32'h5b9cca4f;  6'd55: kRom = 32'h682e6ff3;
         6'd56: kRom = 32'h748f82ee;  6'd57: kRom = 32'h78a5636f;
         6'd58: kRom = 32'h84c87814;  6'd59: kRom = 32'h8cc70208;
         6'd60: kRom = 32'h90befffa;  6'd61: kRom = 32'ha4506ceb;
         6'd62: kRom = 32'hbef9a3f7;  default: kRom = 32'hc67178f2;
      endcase
   endfunction

   assign w_ready      = (stateReg == ROUND);
   assign busy         = (stateReg != IDLE);
   assign digest_valid = digestValidReg;
   assign transfer     = w_ready && w_valid;

   // Per-lane chain selection, final addition and output packing (H0 in the top word).
   for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign chainSel[gi]               = use_iv ? IV[255-32*gi -: 32] : h_in[255-32*gi -: 32];
      assign laneSum[gi]                = chainReg[gi] + varReg[gi];
      assign digest[255-32*gi -: 32]    = digestReg[gi];
   end

   // One round of compression on the current working variables.
   always_comb begin
      kWord = kRom(6'(roundReg));
      bigS1 = {varReg[4][5:0], varReg[4][31:6]} ^ {varReg[4][10:0], varReg[4][31:11]}
            ^ {varReg[4][24:0], varReg[4][31:25]};
      bigS0 = {varReg[0][1:0], varReg[0][31:2]} ^ {varReg[0][12:0], varReg[0][31:13]}
            ^ {varReg[0][21:0], varReg[0][31:22]};
      chE   = (varReg[4] & varReg[5]) ^ (~varReg[4] & varReg[6]);
      majA  = (varReg[0] & varReg[1]) ^ (varReg[0] & varReg[2]) ^ (varReg[1] & varReg[2]);
      t1    = varReg[7] + bigS1 + chE + kWord + w_data;
      t2    = bigS0 + majA;
   end

   // Next-state logic; start is only honoured in IDLE.
   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         IDLE:    if (start) stateNext = LOAD;
         LOAD:    stateNext = ROUND;
         ROUND:   if (w_valid && roundReg == LAST_ROUND) stateNext = FINAL;
         FINAL:   stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) stateReg <= IDLE;
      else      stateReg <= stateNext;
   end

   // Round counter: cleared in LOAD, advanced per transfer, saturates at the last round.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         roundReg <= '0;
      end else if (stateReg == LOAD) begin
         roundReg <= '0;
      end else if (transfer && roundReg != LAST_ROUND) begin
         roundReg <= roundReg + 1'b1;
      end
   end

   // Chaining value captured together with an accepted start.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++) chainReg[i] <= '0;
      end else if (stateReg == IDLE && start) begin
         for (int i = 0; i < 8; i++) chainReg[i] <= chainSel[i];
      end
   end

   // Working variables: loaded from the chain, then shifted one round per transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++) varReg[i] <= '0;
      end else if (stateReg == LOAD) begin
         for (int i = 0; i < 8; i++) varReg[i] <= chainReg[i];
      end else if (transfer) begin
         varReg[0] <= t1 + t2;
         varReg[1] <= varReg[0];
         varReg[2] <= varReg[1];
         varReg[3] <= varReg[2];
         varReg[4] <= varReg[3] + t1;
         varReg[5] <= varReg[4];
         varReg[6] <= varReg[5];
         varReg[7] <= varReg[6];
      end
   end

   // Digest update in FINAL with a one-cycle valid pulse; the digest holds otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         digestValidReg <= 1'b0;
         for (int i = 0; i < 8; i++) digestReg[i] <= '0;
      end else begin
         digestValidReg <= (stateReg == FINAL);
         if (stateReg == FINAL) begin
            for (int i = 0; i < 8; i++) digestReg[i] <= laneSum[i];
         end
      end
   end

endmodule
